// File: rtl/dt_pass_sched_pkg.sv
// Shared types and constants for the distance-transform pass scheduler.
// Imported by the interface, the RAM port mux and the top-level sequencer.
package dt_pass_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_UNPACK,
      ST_FW_START,
      ST_FW_WAIT,
      ST_BC_START,
      ST_BC_WAIT,
      ST_DONE
   } state_t;

   localparam logic [7:0] OBJ_VAL_DEF = 8'h01;
   localparam logic [7:0] BG_VAL_DEF  = 8'h00;

   localparam int IMG_W         = 128;
   localparam int PIX_PER_WORD  = 16;
   localparam int RAM_DEPTH     = IMG_W * IMG_W;
   localparam int STI_WORDS_DEF = RAM_DEPTH / PIX_PER_WORD;

   localparam int STI_AW = 10;
   localparam int RES_AW = 14;

   localparam logic MODE_FW = 1'b0;
   localparam logic MODE_BC = 1'b1;

   function automatic logic [7:0] pix_byte(input logic       i_bit,
                                           input logic [7:0] i_obj,
                                           input logic [7:0] i_bg);
      return i_bit ? i_obj : i_bg;
   endfunction

endpackage

// File: rtl/dt_pass_sched_if.sv
// Handshake and RAM-request bundle between the scheduler (master) and the pass engine (slave).
interface dt_pass_sched_if;
   import dt_pass_sched_pkg::*;

   logic              eng_start;
   logic              eng_mode;
   logic              eng_done;
   logic              eng_res_wr;
   logic              eng_res_rd;
   logic [RES_AW-1:0] eng_res_addr;
   logic [7:0]        eng_res_do;
   logic [7:0]        eng_res_di;

   modport master (
      output eng_start, eng_mode, eng_res_di,
      input  eng_done, eng_res_wr, eng_res_rd, eng_res_addr, eng_res_do
   );

   modport slave (
      input  eng_start, eng_mode, eng_res_di,
      output eng_done, eng_res_wr, eng_res_rd, eng_res_addr, eng_res_do
   );

endinterface

// File: rtl/dt_res_mux.sv
// Result-RAM port multiplexer: the loader owns the port unless the engine is granted it.
module dt_res_mux
   import dt_pass_sched_pkg::*;
(
   input  logic              i_sel_eng,
   input  logic              i_ld_wr,
   input  logic              i_ld_rd,
   input  logic [RES_AW-1:0] i_ld_addr,
   input  logic [7:0]        i_ld_do,
   input  logic              i_eng_wr,
   input  logic              i_eng_rd,
   input  logic [RES_AW-1:0] i_eng_addr,
   input  logic [7:0]        i_eng_do,
   output logic              o_wr,
   output logic              o_rd,
   output logic [RES_AW-1:0] o_addr,
   output logic [7:0]        o_do
);

   always_comb begin
      if (i_sel_eng) begin
         o_wr   = i_eng_wr;
         o_rd   = i_eng_rd;
         o_addr = i_eng_addr;
         o_do   = i_eng_do;
      end else begin
         o_wr   = i_ld_wr;
         o_rd   = i_ld_rd;
         o_addr = i_ld_addr;
         o_do   = i_ld_do;
      end
   end

endmodule

// File: rtl/dt_pass_sched.sv
// Distance-transform sequencer: unpacks the ROM image into the result RAM one byte per
// pixel, then runs the external engine forward and backward, lending it the RAM port.
module dt_pass_sched
   import dt_pass_sched_pkg::*;
#(
   parameter int         STI_WORDS = STI_WORDS_DEF,
   parameter logic [7:0] OBJ_VAL   = OBJ_VAL_DEF,
   parameter logic [7:0] BG_VAL    = BG_VAL_DEF,
   parameter bit         SKIP_BG   = 1'b0
)
(
   input  logic              clk,
   input  logic              reset,
   output logic              sti_rd,
   output logic [STI_AW-1:0] sti_addr,
   input  logic [15:0]       sti_di,
   output logic              res_wr,
   output logic              res_rd,
   output logic [RES_AW-1:0] res_addr,
   output logic [7:0]        res_do,
   input  logic [7:0]        res_di,
   output logic              fwpass_finish,
   output logic              done,
   dt_pass_sched_if.master   eng
);

   localparam logic [STI_AW-1:0] LAST_WORD = STI_AW'(STI_WORDS - 1);

   state_t            r_state;
   state_t            w_next;
   logic [STI_AW-1:0] r_word;
   logic [3:0]        r_bit;
   logic [15:0]       r_shift;

   logic              w_pix;
   logic              w_ld_wr;
   logic [7:0]        w_ld_do;
   logic              w_sel_eng;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Word/bit counters and the pixel shift register advance only in the load states.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               r_shift <= sti_di;
               r_bit   <= '0;
            end
            ST_UNPACK: begin
               r_bit <= r_bit + 4'd1;
               if (r_bit == 4'hF && r_word != LAST_WORD) begin
                  r_word <= r_word + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Pixel k of the word sits at bit 15-k, which is simply the bitwise inverse of k.
   assign w_pix = r_shift[~r_bit];

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      w_next        = r_state;
      sti_rd        = 1'b0;
      w_ld_wr       = 1'b0;
      w_ld_do       = 8'h00;
      w_sel_eng     = 1'b0;
      eng.eng_start = 1'b0;
      eng.eng_mode  = MODE_FW;
      fwpass_finish = 1'b0;
      done          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_next = ST_FETCH;
         end
         ST_FETCH: begin
            sti_rd = 1'b1;
            w_next = ST_UNPACK;
         end
         ST_UNPACK: begin
            w_ld_wr = w_pix || !SKIP_BG;
            w_ld_do = pix_byte(w_pix, OBJ_VAL, BG_VAL);
            if (r_bit == 4'hF) begin
               w_next = (r_word == LAST_WORD) ? ST_FW_START : ST_FETCH;
            end
         end
         ST_FW_START: begin
            eng.eng_start = 1'b1;
            w_next        = ST_FW_WAIT;
         end
         ST_FW_WAIT: begin
            w_sel_eng = 1'b1;
            if (eng.eng_done) begin
               w_next = ST_BC_START;
            end
         end
         ST_BC_START: begin
            eng.eng_start = 1'b1;
            eng.eng_mode  = MODE_BC;
            fwpass_finish = 1'b1;
            w_next        = ST_BC_WAIT;
         end
         ST_BC_WAIT: begin
            w_sel_eng    = 1'b1;
            eng.eng_mode = MODE_BC;
            if (eng.eng_done) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign sti_addr       = r_word;
   assign eng.eng_res_di = res_di;

   dt_res_mux u_res_mux (
      .i_sel_eng  (w_sel_eng),
      .i_ld_wr    (w_ld_wr),
      .i_ld_rd    (1'b0),
      .i_ld_addr  ({r_word, r_bit}),
      .i_ld_do    (w_ld_do),
      .i_eng_wr   (eng.eng_res_wr),
      .i_eng_rd   (eng.eng_res_rd),
      .i_eng_addr (eng.eng_res_addr),
      .i_eng_do   (eng.eng_res_do),
      .o_wr       (res_wr),
      .o_rd       (res_rd),
      .o_addr     (res_addr),
      .o_do       (res_do)
   );

endmodule
